// File: rtl/id_ex_stage_if.sv
// D/E boundary bundle: decode-side inputs, execute-side registered outputs, hazard signals.
interface id_ex_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 16;

    // Decode side
    logic            ValidD;
    logic            RegWriteD;
    logic            MemWriteD;
    logic            BranchD;
    logic            JumpD;
    logic            ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ImmExtD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [REGW-1:0] Rs1D;
    logic [REGW-1:0] Rs2D;
    logic [REGW-1:0] RdD;
    logic            FlushE;
    logic            ClearCount;

    // Execute side
    logic            ValidE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            BranchE;
    logic            JumpE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [REGW-1:0] Rs1E;
    logic [REGW-1:0] Rs2E;
    logic [REGW-1:0] RdE;

    // Hazard / monitoring
    logic            StallD;
    logic [CNTW-1:0] StallCount;

    modport master (
        output ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD,
               RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, FlushE, ClearCount,
        input  ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, StallD, StallCount
    );

    modport slave (
        input  ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD,
               RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, FlushE, ClearCount,
        output ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, StallD, StallCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles and a stall counter.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 16;

    logic            loadUse;
    logic            bubble;
    logic            ctlKeep;
    logic            dataKeep;
    logic [CNTW-1:0] stallCountQ;

    // Load in execute whose destination feeds a source of the real instruction in decode
    always_comb begin
        loadUse = bus.ValidE & bus.RegWriteE & (bus.ResultSrcE == 2'b01) &
                  (bus.RdE != REGW'(0)) & bus.ValidD &
                  ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));
        bubble   = bus.FlushE | loadUse;
        ctlKeep  = ~bubble & bus.ValidD;
        dataKeep = ~bubble;
    end

    // A flush suppresses the stall: the decode slot is being squashed anyway
    assign bus.StallD     = loadUse & ~bus.FlushE;
    assign bus.StallCount = stallCountQ;

    // Pipeline register; controls zeroed for bubbles and invalid slots, data zeroed for bubbles only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ValidE      <= 1'b0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.ALUControlE <= 3'b000;
            bus.RD1E        <= XLEN'(0);
            bus.RD2E        <= XLEN'(0);
            bus.ImmExtE     <= XLEN'(0);
            bus.PCE         <= XLEN'(0);
            bus.PCPlus4E    <= XLEN'(0);
            bus.Rs1E        <= REGW'(0);
            bus.Rs2E        <= REGW'(0);
            bus.RdE         <= REGW'(0);
        end else begin
            bus.ValidE      <= ctlKeep;
            bus.RegWriteE   <= ctlKeep & bus.RegWriteD;
            bus.MemWriteE   <= ctlKeep & bus.MemWriteD;
            bus.BranchE     <= ctlKeep & bus.BranchD;
            bus.JumpE       <= ctlKeep & bus.JumpD;
            bus.ALUSrcE     <= ctlKeep & bus.ALUSrcD;
            bus.ResultSrcE  <= ctlKeep ? bus.ResultSrcD : 2'b00;
            bus.ALUControlE <= ctlKeep ? bus.ALUControlD : 3'b000;
            bus.RD1E        <= dataKeep ? bus.RD1D : XLEN'(0);
            bus.RD2E        <= dataKeep ? bus.RD2D : XLEN'(0);
            bus.ImmExtE     <= dataKeep ? bus.ImmExtD : XLEN'(0);
            bus.PCE         <= dataKeep ? bus.PCD : XLEN'(0);
            bus.PCPlus4E    <= dataKeep ? bus.PCPlus4D : XLEN'(0);
            bus.Rs1E        <= dataKeep ? bus.Rs1D : REGW'(0);
            bus.Rs2E        <= dataKeep ? bus.Rs2D : REGW'(0);
            bus.RdE         <= dataKeep ? bus.RdD : REGW'(0);
        end
    end

    // Saturating load-use stall counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCountQ <= CNTW'(0);
        end else if (bus.ClearCount) begin
            stallCountQ <= CNTW'(0);
        end else if (bus.StallD && (stallCountQ != {CNTW{1'b1}})) begin
            stallCountQ <= stallCountQ + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl packing: {RegWrite, MemWrite, Branch, Jump, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    typedef struct {
        logic        v;
        logic [9:0]  dCtrl;
        logic [31:0] rd1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        flush;
        logic        clr;
        logic        eStall;
        logic        eValid;
        logic [9:0]  eCtrl;
        logic        eData;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic v, input logic [9:0] dCtrl, input logic [31:0] rd1,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic flush, input logic clr, input logic eStall,
                                input logic eValid, input logic [9:0] eCtrl, input logic eData,
                                input logic [15:0] eCnt);
        vec_t r;
        r.v = v; r.dCtrl = dCtrl; r.rd1 = rd1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.flush = flush; r.clr = clr; r.eStall = eStall; r.eValid = eValid;
        r.eCtrl = eCtrl; r.eData = eData; r.eCnt = eCnt;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.ValidD      = t.v;
        bus.RegWriteD   = t.dCtrl[9];
        bus.MemWriteD   = t.dCtrl[8];
        bus.BranchD     = t.dCtrl[7];
        bus.JumpD       = t.dCtrl[6];
        bus.ALUSrcD     = t.dCtrl[5];
        bus.ResultSrcD  = t.dCtrl[4:3];
        bus.ALUControlD = t.dCtrl[2:0];
        bus.RD1D        = t.rd1;
        bus.RD2D        = ~t.rd1;
        bus.ImmExtD     = t.rd1 ^ 32'h0F0F_0F0F;
        bus.PCD         = t.rd1 + 32'h0000_0100;
        bus.PCPlus4D    = t.rd1 + 32'h0000_0104;
        bus.Rs1D        = t.rs1;
        bus.Rs2D        = t.rs2;
        bus.RdD         = t.rd;
        bus.FlushE      = t.flush;
        bus.ClearCount  = t.clr;
    endtask

    // Called at a negedge: drive, check StallD, clock, check E outputs at the next negedge
    task automatic runVec(input vec_t t, input int idx);
        logic [127:0] expData;
        logic [14:0]  expIdx;
        drive(t);
        #1;
        check("StallD", idx, 64'(bus.StallD), 64'(t.eStall));
        @(posedge clk);
        @(negedge clk);
        expData = t.eData ? {~t.rd1, t.rd1 ^ 32'h0F0F_0F0F, t.rd1 + 32'h0000_0100, t.rd1 + 32'h0000_0104} : 128'd0;
        expIdx  = t.eData ? {t.rs1, t.rs2, t.rd} : 15'd0;
        check("ValidE", idx, 64'(bus.ValidE), 64'(t.eValid));
        check("CtrlE", idx, 64'({bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUSrcE,
                                 bus.ResultSrcE, bus.ALUControlE}), 64'(t.eCtrl));
        check("RD1E", idx, 64'(bus.RD1E), t.eData ? 64'(t.rd1) : 64'd0);
        check("DataE_hi", idx, {bus.RD2E, bus.ImmExtE}, expData[127:64]);
        check("DataE_lo", idx, {bus.PCE, bus.PCPlus4E}, expData[63:0]);
        check("IdxE", idx, 64'({bus.Rs1E, bus.Rs2E, bus.RdE}), 64'(expIdx));
        check("StallCount", idx, 64'(bus.StallCount), 64'(t.eCnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        //            v  dCtrl   rd1           rs1 rs2 rd  fl clr | st vE eCtrl  eD eCnt
        vecs[0]  = mk(1, 10'h202, 32'h1234_5678, 1,  2,  5,  0, 0,   0, 1, 10'h202, 1, 0); // pass-through
        vecs[1]  = mk(1, 10'h208, 32'h0000_000A, 3,  4,  7,  0, 0,   0, 1, 10'h208, 1, 0); // load x7
        vecs[2]  = mk(1, 10'h200, 32'h0000_000B, 8,  7,  9,  0, 0,   1, 0, 10'h000, 0, 1); // use via Rs2
        vecs[3]  = mk(1, 10'h200, 32'h0000_000B, 8,  7,  9,  0, 0,   0, 1, 10'h200, 1, 1); // held instr advances
        vecs[4]  = mk(1, 10'h208, 32'h0000_000C, 0,  0,  0,  0, 0,   0, 1, 10'h208, 1, 1); // load x0
        vecs[5]  = mk(1, 10'h200, 32'h0000_000D, 0,  0,  6,  0, 0,   0, 1, 10'h200, 1, 1); // x0 never stalls
        vecs[6]  = mk(1, 10'h208, 32'h0000_000E, 1,  2,  10, 0, 0,   0, 1, 10'h208, 1, 1); // load x10
        vecs[7]  = mk(1, 10'h200, 32'h0000_000F, 10, 3,  11, 1, 0,   0, 0, 10'h000, 0, 1); // flush beats load-use
        vecs[8]  = mk(0, 10'h3EF, 32'hDEAD_BEEF, 4,  5,  3,  0, 0,   0, 0, 10'h000, 1, 1); // invalid slot
        vecs[9]  = mk(1, 10'h208, 32'h0000_0010, 1,  1,  12, 0, 0,   0, 1, 10'h208, 1, 1); // load x12
        vecs[10] = mk(1, 10'h200, 32'h0000_0011, 5,  12, 14, 0, 1,   1, 0, 10'h000, 0, 0); // clear during stall
        vecs[11] = mk(1, 10'h1F5, 32'h0000_0012, 12, 13, 13, 0, 0,   0, 1, 10'h1F5, 1, 0); // all other controls
        vecs[12] = mk(1, 10'h200, 32'h0000_0013, 1,  2,  3,  1, 0,   0, 0, 10'h000, 0, 0); // plain flush
        vecs[13] = mk(1, 10'h208, 32'h0000_0014, 0,  0,  7,  0, 0,   0, 1, 10'h208, 1, 0); // load x7
        vecs[14] = mk(0, 10'h200, 32'h0000_0015, 7,  0,  4,  0, 0,   0, 0, 10'h000, 1, 0); // invalid D: no stall
        vecs[15] = mk(1, 10'h208, 32'h0000_0016, 0,  0,  8,  0, 0,   0, 1, 10'h208, 1, 0); // load x8
        vecs[16] = mk(1, 10'h200, 32'h0000_0017, 8,  0,  9,  0, 0,   1, 0, 10'h000, 0, 1); // use via Rs1
        vecs[17] = mk(1, 10'h008, 32'h0000_0018, 0,  0,  9,  0, 0,   0, 1, 10'h008, 1, 1); // memory-result, no RegWrite
        vecs[18] = mk(1, 10'h200, 32'h0000_0019, 9,  0,  2,  0, 0,   0, 1, 10'h200, 1, 1); // no stall without RegWriteE

        // Reset with nonzero decode inputs
        rst_n = 1'b0;
        drive(mk(1, 10'h3FF, 32'hFFFF_FFFF, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ValidE", 0, 64'(bus.ValidE), 64'd0);
        check("rst_Ctrl", 0, 64'({bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUSrcE,
                                  bus.ResultSrcE, bus.ALUControlE}), 64'd0);
        check("rst_Data", 0, {bus.RD1E, bus.PCE}, 64'd0);
        check("rst_Idx", 0, 64'({bus.Rs1E, bus.Rs2E, bus.RdE}), 64'd0);
        check("rst_StallD", 0, 64'(bus.StallD), 64'd0);
        check("rst_Count", 0, 64'(bus.StallCount), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) runVec(vecs[i], i);

        // Saturation: preload near the top, then two more stalls
        force dut.stallCountQ = 16'hFFFE;
        #1;
        release dut.stallCountQ;
        check("preload", 0, 64'(bus.StallCount), 64'hFFFE);
        runVec(mk(1, 10'h208, 32'h0000_0020, 0,  0,  20, 0, 0, 0, 1, 10'h208, 1, 16'hFFFE), 100);
        runVec(mk(1, 10'h200, 32'h0000_0021, 1,  20, 21, 0, 0, 1, 0, 10'h000, 0, 16'hFFFF), 101);
        runVec(mk(1, 10'h200, 32'h0000_0021, 1,  20, 21, 0, 0, 0, 1, 10'h200, 1, 16'hFFFF), 102);
        runVec(mk(1, 10'h208, 32'h0000_0022, 0,  0,  22, 0, 0, 0, 1, 10'h208, 1, 16'hFFFF), 103);
        runVec(mk(1, 10'h200, 32'h0000_0023, 22, 0,  23, 0, 0, 1, 0, 10'h000, 0, 16'hFFFF), 104);
        runVec(mk(1, 10'h200, 32'h0000_0023, 22, 0,  23, 0, 1, 0, 1, 10'h200, 1, 16'h0000), 105);

        // Build up a nonzero count and live E state, then reset asynchronously mid-cycle
        runVec(mk(1, 10'h208, 32'h0000_0030, 0,  0,  24, 0, 0, 0, 1, 10'h208, 1, 0), 106);
        runVec(mk(1, 10'h200, 32'h0000_0031, 24, 0,  25, 0, 0, 1, 0, 10'h000, 0, 1), 107);
        runVec(mk(1, 10'h208, 32'h0000_0032, 0,  0,  26, 0, 0, 0, 1, 10'h208, 1, 1), 108);
        drive(mk(1, 10'h200, 32'h0000_0033, 26, 0, 27, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre_async_StallD", 0, 64'(bus.StallD), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_ValidE", 0, 64'(bus.ValidE), 64'd0);
        check("async_RegWriteE", 0, 64'(bus.RegWriteE), 64'd0);
        check("async_RdE", 0, 64'(bus.RdE), 64'd0);
        check("async_Count", 0, 64'(bus.StallCount), 64'd0);
        check("async_StallD", 0, 64'(bus.StallD), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release captures normally
        runVec(mk(1, 10'h202, 32'h1234_5678, 1, 2, 5, 0, 0, 0, 1, 10'h202, 1, 0), 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
